picosoc_timer: RTL and testbench

Memory-mapped countdown timer and microsecond timebase responder on the PicoSoC iomem bus. It is mapped at 0x09xx_xxxx. It gives firmware a free-running microsecond counter for SD-card timeouts and OSD pacing, plus a one-shot/periodic countdown with an interrupt line for the PicoRV32 `irq` vector. It is the responder side of the CPU's valid/ready iomem protocol.

---
 rtl/picosoc_timer_pkg.sv | 44 ++++
 rtl/picosoc_timer_if.sv | 21 ++
 rtl/picosoc_us_prescaler.sv | 30 +++
 rtl/picosoc_timer.sv | 142 ++++++++++++++
 tb/tb_picosoc_timer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/picosoc_timer_pkg.sv
// Shared constants, control-register layout and helpers for the PicoSoC timer.
package picosoc_timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CTRL_W = 3;

    localparam logic [IDX_W-1:0] REG_CTRL   = 3'd0;
    localparam logic [IDX_W-1:0] REG_STATUS = 3'd1;
    localparam logic [IDX_W-1:0] REG_LOAD   = 3'd2;
    localparam logic [IDX_W-1:0] REG_COUNT  = 3'd3;
    localparam logic [IDX_W-1:0] REG_USEC   = 3'd4;
    localparam logic [IDX_W-1:0] REG_DIV    = 3'd5;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_PERIODIC_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 2;
    localparam int unsigned STATUS_EXPIRED_BIT = 0;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic enable;
    } timer_ctrl_t;

    // Prescaler terminal value: clock cycles per microsecond minus one.
    function automatic logic [DATA_W-1:0] calc_div(input int unsigned clock_hz);
        return DATA_W'(clock_hz / 1_000_000 - 1);
    endfunction

    // Merge new_val into old_val for every byte lane whose strobe is set.
    function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_val,
                                                      input logic [DATA_W-1:0] new_val,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/picosoc_timer_if.sv
// PicoSoC iomem valid/ready bus as seen by one memory-mapped responder.
interface picosoc_timer_if;
    import picosoc_timer_pkg::*;

    logic              iomem_valid;
    logic [STRB_W-1:0] iomem_wstrb;
    logic [DATA_W-1:0] iomem_addr;
    logic [DATA_W-1:0] iomem_wdata;
    logic [DATA_W-1:0] iomem_rdata;
    logic              iomem_ready;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_rdata, iomem_ready
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_rdata, iomem_ready
    );
endinterface

// File: rtl/picosoc_us_prescaler.sv
// Microsecond prescaler and free-running 32-bit microsecond counter.
module picosoc_us_prescaler
    import picosoc_timer_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              us_tick,
    output logic [DATA_W-1:0] usec
);

    localparam logic [DATA_W-1:0] DIV_VALUE = calc_div(CLOCK_SPEED_HZ);

    logic [DATA_W-1:0] presc_q;

    // us_tick is high exactly while the prescaler sits at its terminal value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
            us_tick <= 1'b0;
            usec    <= '0;
        end else begin
            presc_q <= (presc_q == DIV_VALUE) ? '0 : presc_q + DATA_W'(1);
            us_tick <= (presc_q == DIV_VALUE - DATA_W'(1));
            if (us_tick) usec <= usec + DATA_W'(1);
        end
    end

endmodule

// File: rtl/picosoc_timer.sv
// iomem responder: countdown timer with sticky expiry interrupt plus USEC/DIV readback.
module picosoc_timer
    import picosoc_timer_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ = 50_000_000
) (
    input  logic           clk,
    input  logic           resetn,
    picosoc_timer_if.slave bus,
    output logic           irq_o
);

    localparam logic [DATA_W-1:0] DIV_VALUE = calc_div(CLOCK_SPEED_HZ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [0:0]        state_q, state_next;
    logic              ready_q, ready_next;
    logic [DATA_W-1:0] rdata_q, rdata_next;
    logic              accept;

    timer_ctrl_t       ctrl_q, ctrl_next;
    logic              expired_q, expired_next;
    logic [DATA_W-1:0] load_q, load_next;
    logic [DATA_W-1:0] count_q, count_next;

    logic              us_tick;
    logic [DATA_W-1:0] usec;

    logic [IDX_W-1:0]  reg_idx;
    logic              wr_en;
    logic              byte0_wr;
    logic [DATA_W-1:0] rd_val;
    logic              unused_addr_bits;

    picosoc_us_prescaler #(
        .CLOCK_SPEED_HZ(CLOCK_SPEED_HZ)
    ) u_presc (
        .clk    (clk),
        .resetn (resetn),
        .us_tick(us_tick),
        .usec   (usec)
    );

    assign reg_idx          = bus.iomem_addr[4:2];
    assign wr_en            = accept && (bus.iomem_wstrb != '0);
    assign byte0_wr         = wr_en && bus.iomem_wstrb[0];
    assign unused_addr_bits = ^{bus.iomem_addr[DATA_W-1:5], bus.iomem_addr[1:0]};

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign irq_o           = expired_q & ctrl_q.irq_en;

    // Register readback, always reflecting state before this cycle's write.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_CTRL:   rd_val = DATA_W'(ctrl_q);
            REG_STATUS: rd_val = DATA_W'(expired_q);
            REG_LOAD:   rd_val = load_q;
            REG_COUNT:  rd_val = count_q;
            REG_USEC:   rd_val = usec;
            REG_DIV:    rd_val = DIV_VALUE;
            default:    rd_val = '0;
        endcase
    end

    // Bus FSM: accept in IDLE, pulse ready for one cycle in ACK.
    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iomem_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        ready_next = (state_next == ST_ACK);
        rdata_next = accept ? rd_val : '0;
    end

    // Countdown first, then CPU writes so that the CPU wins on COUNT and CTRL.
    always_comb begin
        ctrl_next    = ctrl_q;
        expired_next = expired_q;
        load_next    = load_q;
        count_next   = count_q;

        if (wr_en && reg_idx == REG_STATUS && bus.iomem_wstrb[0]
            && bus.iomem_wdata[STATUS_EXPIRED_BIT]) begin
            expired_next = 1'b0;
        end

        if (us_tick && ctrl_q.enable) begin
            if (count_q != '0) begin
                count_next = count_q - DATA_W'(1);
            end else begin
                expired_next = 1'b1;
                if (ctrl_q.periodic) count_next = load_q;
                else                 ctrl_next.enable = 1'b0;
            end
        end

        if (byte0_wr && reg_idx == REG_CTRL) begin
            ctrl_next.enable   = bus.iomem_wdata[CTRL_ENABLE_BIT];
            ctrl_next.periodic = bus.iomem_wdata[CTRL_PERIODIC_BIT];
            ctrl_next.irq_en   = bus.iomem_wdata[CTRL_IRQ_EN_BIT];
        end
        if (wr_en && reg_idx == REG_LOAD) begin
            load_next = apply_wstrb(load_q, bus.iomem_wdata, bus.iomem_wstrb);
        end
        if (wr_en && reg_idx == REG_COUNT) begin
            count_next = apply_wstrb(count_q, bus.iomem_wdata, bus.iomem_wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            expired_q <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_next;
            ready_q   <= ready_next;
            rdata_q   <= rdata_next;
            ctrl_q    <= ctrl_next;
            expired_q <= expired_next;
            load_q    <= load_next;
            count_q   <= count_next;
        end
    end

endmodule

// File: tb/tb_picosoc_timer.sv
// Randomised and directed bench for picosoc_timer against a cycle-count based reference model.
module tb_picosoc_timer;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned DIV    = CLK_HZ / 1_000_000 - 1;

    logic clk;
    logic resetn;
    logic irq_o;

    picosoc_timer_if bus ();

    picosoc_timer #(
        .CLOCK_SPEED_HZ(CLK_HZ)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus),
        .irq_o (irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model state.
    int unsigned cyc;
    logic        m_en, m_per, m_irq, m_exp, m_ready;
    logic [31:0] m_load, m_count, m_usec, m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return {29'd0, m_irq, m_per, m_en};
            3'd1:    return {31'd0, m_exp};
            3'd2:    return m_load;
            3'd3:    return m_count;
            3'd4:    return m_usec;
            3'd5:    return 32'(DIV);
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across the coming clock edge using the inputs now driven.
    task automatic model_step();
        logic        tick, acc, wr, exp_now, en_after;
        logic [2:0]  idx;
        logic [31:0] cnt_after;
        if (!resetn) begin
            cyc = 0;
            m_en = 0; m_per = 0; m_irq = 0; m_exp = 0; m_ready = 0;
            m_load = 0; m_count = 0; m_usec = 0; m_rdata = 0;
        end else begin
            tick      = (cyc % (DIV + 1)) == DIV;
            acc       = bus.iomem_valid && !m_ready;
            idx       = bus.iomem_addr[4:2];
            wr        = acc && (bus.iomem_wstrb != 4'd0);
            m_rdata   = acc ? model_read(idx) : 32'd0;
            m_ready   = acc;
            exp_now   = 0;
            en_after  = m_en;
            cnt_after = m_count;
            if (tick && m_en) begin
                if (m_count != 0) cnt_after = m_count - 1;
                else begin
                    exp_now = 1;
                    if (m_per) cnt_after = m_load;
                    else       en_after  = 0;
                end
            end
            if (wr && idx == 3'd1 && bus.iomem_wstrb[0] && bus.iomem_wdata[0]) m_exp = 0;
            if (exp_now) m_exp = 1;
            m_en = en_after;
            if (wr && idx == 3'd0 && bus.iomem_wstrb[0]) begin
                m_en  = bus.iomem_wdata[0];
                m_per = bus.iomem_wdata[1];
                m_irq = bus.iomem_wdata[2];
            end
            if (wr && idx == 3'd3) cnt_after = merge(m_count, bus.iomem_wdata, bus.iomem_wstrb);
            if (wr && idx == 3'd2) m_load = merge(m_load, bus.iomem_wdata, bus.iomem_wstrb);
            m_count = cnt_after;
            if (tick) m_usec = m_usec + 1;
            cyc++;
        end
    endtask

    // One clock: model step, edge, then compare every observable output.
    task automatic tick_clk();
        model_step();
        @(posedge clk);
        #1;
        check("ready", 32'(bus.iomem_ready), 32'(m_ready));
        check("rdata", bus.iomem_rdata, m_rdata);
        check("irq",   32'(irq_o), 32'(m_exp & m_irq));
    endtask

    task automatic bus_access(input logic [2:0] idx, input logic [3:0] strb,
                              input logic [31:0] data, output logic [31:0] rd);
        int n;
        n = 0;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {27'($urandom), idx, 2'($urandom)};
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = data;
        do begin
            tick_clk();
            n++;
        end while (!bus.iomem_ready && n < 8);
        check("bus_ack", 32'(bus.iomem_ready), 32'd1);
        rd = bus.iomem_rdata;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        bus.iomem_wdata = $urandom;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data);
        logic [31:0] d;
        bus_access(idx, 4'hF, data, d);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_access(idx, 4'h0, $urandom, d);
        check(tag, d, exp);
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 400 && !irq_o; i++) tick_clk();
        check(tag, 32'(irq_o), 32'd1);
    endtask

    // Advance until the current cycle has the given prescaler phase.
    task automatic wait_phase(input int unsigned p);
        while ((cyc % (DIV + 1)) != p) tick_clk();
    endtask

    task automatic reset_reads(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_chk(tag, 3'(i), (i == 5) ? 32'd49 : 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        n_checks = 0;
        n_pass   = 0;
        resetn          = 1'b0;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        bus.iomem_addr  = 32'd0;
        bus.iomem_wdata = 32'd0;
        repeat (3) tick_clk();
        resetn = 1'b1;
        tick_clk();

        reset_reads("rst_val");

        // Periodic with irq.
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'h7);
        wait_irq("per_irq");
        rd_chk("per_count_reload", 3'd3, 32'd3);
        rd_chk("per_status", 3'd1, 32'd1);
        bus_access(3'd1, 4'h1, 32'd1, d);
        check("per_irq_clear", 32'(irq_o), 32'd0);
        wr(3'd0, 32'd0);

        // One-shot.
        wr(3'd3, 32'd2);
        wr(3'd0, 32'h5);
        wait_irq("os_irq");
        rd_chk("os_ctrl", 3'd0, 32'h4);
        repeat (10 * (DIV + 1)) tick_clk();
        rd_chk("os_count_hold", 3'd3, 32'd0);
        wr(3'd1, 32'd1);

        // Byte strobes.
        wr(3'd3, 32'h1122_3344);
        bus_access(3'd3, 4'h2, 32'hAABB_CCDD, d);
        rd_chk("strb_count", 3'd3, 32'h1122_CC44);

        // COUNT write coincident with a decrement tick.
        wr(3'd3, 32'd100);
        wr(3'd0, 32'h1);
        wait_phase(DIV);
        wr(3'd3, 32'h0000_1234);
        rd_chk("count_wr_on_tick", 3'd3, 32'h0000_1234);
        wr(3'd0, 32'd0);

        // STATUS clear coincident with an expiry (enable with COUNT=0).
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h3);
        wait_phase(DIV);
        bus_access(3'd1, 4'h1, 32'd1, d);
        rd_chk("clr_on_expiry", 3'd1, 32'd1);
        rd_chk("clr_on_expiry_reload", 3'd3, 32'd5);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd1);

        // USEC wrap.
        wait_phase(0);
        force dut.u_presc.usec = 32'hFFFF_FFFE;
        m_usec = 32'hFFFF_FFFE;
        tick_clk();
        release dut.u_presc.usec;
        rd_chk("usec_preload", 3'd4, 32'hFFFF_FFFE);
        repeat (2 * (DIV + 1)) tick_clk();
        rd_chk("usec_wrap", 3'd4, 32'd0);

        // Random traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 250; k++) begin
            logic [3:0]  s;
            logic [31:0] v;
            s = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            v = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 5);
            bus_access(3'($urandom_range(0, 7)), s, v, d);
            repeat ($urandom_range(0, 3)) tick_clk();
        end
        repeat (300) tick_clk();

        // Reset asserted in the accept cycle of a LOAD write.
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0900_0008;
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'hDEAD_BEEF;
        resetn = 1'b0;
        tick_clk();
        check("rst_mid_ready", 32'(bus.iomem_ready), 32'd0);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        tick_clk();
        resetn = 1'b1;
        tick_clk();
        check("rst_mid_irq", 32'(irq_o), 32'd0);
        reset_reads("rst_mid_val");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
